// File: rtl/gcd_control_if.sv
// Handshake and datapath-control bundle between gcd_control and its issuer/datapath.
// Purely combinational wiring; no latency of its own.
// No backpressure: start is a level request, sampled only when the controller is idle.
//
// Signals: start (request), x_lt_y/x_ne_y (datapath flags), x_sel/y_sel/x_en/y_en/
// output_en (datapath controls), busy/done/err (status), iter_count (subtraction count).
interface gcd_control_if #(
    parameter int ITER_W = 16
);
    logic              start;
    logic              x_lt_y;
    logic              x_ne_y;
    logic              x_sel;
    logic              y_sel;
    logic              x_en;
    logic              y_en;
    logic              output_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter_count;

    // The controller side.
    modport slave (
        input  start, x_lt_y, x_ne_y,
        output x_sel, y_sel, x_en, y_en, output_en, busy, done, err, iter_count
    );

    // The issuer/datapath side.
    modport master (
        output start, x_lt_y, x_ne_y,
        input  x_sel, y_sel, x_en, y_en, output_en, busy, done, err, iter_count
    );
endinterface

// File: rtl/gcd_control.sv
// Control FSM for a subtractive GCD datapath with start/busy/done handshake and timeout.
// Latency: LOAD one cycle after start, output_en at cycle 2+n, done pulse at cycle 3+n.
// Backpressure: none; start is ignored while busy (LOAD/RUN) and re-sampled in IDLE/DONE/ERR.
//
// Ports: clock, reset (async active-low), bus (gcd_control_if.slave) carrying
// start, x_lt_y, x_ne_y in and x_sel, y_sel, x_en, y_en, output_en, busy, done, err,
// iter_count out.
module gcd_control #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 1000
) (
    input  logic          clock,
    input  logic          reset,
    gcd_control_if.slave  bus
);

    if (MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W)) begin : g_bad_max_iter
        $error("gcd_control: MAX_ITER must be in [1, 2**ITER_W - 1]");
    end

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ITER_W-1:0] r_iter;
    logic              r_err;

    logic w_x_sel, w_y_sel, w_x_en, w_y_en, w_output_en, w_busy, w_done;
    logic w_iter_clr;   // LOAD: restart count and clear the sticky error
    logic w_iter_inc;   // RUN: one subtraction performed this cycle
    logic w_err_set;    // RUN: limit reached without convergence

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_iter_clr) begin
                r_iter <= '0;
                r_err  <= 1'b0;
            end else begin
                if (w_iter_inc) r_iter <= r_iter + 1'b1;
                if (w_err_set)  r_err  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_x_sel     = 1'b0;
        w_y_sel     = 1'b0;
        w_x_en      = 1'b0;
        w_y_en      = 1'b0;
        w_output_en = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_iter_clr  = 1'b0;
        w_iter_inc  = 1'b0;
        w_err_set   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_LOAD;
            end
            S_LOAD: begin
                // Both muxes select the external operands.
                w_x_en     = 1'b1;
                w_y_en     = 1'b1;
                w_busy     = 1'b1;
                w_iter_clr = 1'b1;
                w_next     = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                // Convergence wins over the limit check, so a result reached on
                // the very last permitted subtraction is still reported as done.
                if (!bus.x_ne_y) begin
                    w_output_en = 1'b1;
                    w_next      = S_DONE;
                end else if (r_iter == MAX_CNT) begin
                    w_err_set = 1'b1;
                    w_next    = S_ERR;
                end else if (bus.x_lt_y) begin
                    w_y_sel    = 1'b1;
                    w_y_en     = 1'b1;
                    w_iter_inc = 1'b1;
                end else begin
                    w_x_sel    = 1'b1;
                    w_x_en     = 1'b1;
                    w_iter_inc = 1'b1;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = bus.start ? S_LOAD : S_IDLE;
            end
            S_ERR: begin
                if (bus.start) w_next = S_LOAD;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.x_sel      = w_x_sel;
    assign bus.y_sel      = w_y_sel;
    assign bus.x_en       = w_x_en;
    assign bus.y_en       = w_y_en;
    assign bus.output_en  = w_output_en;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = r_err;
    assign bus.iter_count = r_iter;

endmodule

// File: tb/tb_gcd_control.sv
// Directed bench for gcd_control with a small behavioural GCD datapath attached.
// Each operation is traced cycle by cycle (cycle 0 = start sampled) and checked
// against hand-computed cycle numbers, results and counts.
module tb_gcd_control;

    localparam int ITER_W   = 16;
    localparam int MAX_ITER = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    gcd_control_if #(.ITER_W(ITER_W)) bus ();

    gcd_control #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural datapath: X/Y registers, subtract muxes, output latch.
    logic [31:0] ext_x = '0, ext_y = '0;
    logic [31:0] dp_x = '0, dp_y = '0, dp_out = '0;

    assign bus.x_lt_y = (dp_x < dp_y);
    assign bus.x_ne_y = (dp_x != dp_y);

    always @(posedge clock) begin
        if (bus.x_en)      dp_x   <= bus.x_sel ? dp_x - dp_y : ext_x;
        if (bus.y_en)      dp_y   <= bus.y_sel ? dp_y - dp_x : ext_y;
        if (bus.output_en) dp_out <= dp_x;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle traces of the last operation.
    logic [63:0] t_xen, t_yen, t_xsel, t_ysel, t_oen, t_busy, t_done, t_err;

    function automatic int first_hi(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input bit hold, input int ncyc);
        t_xen = '0; t_yen = '0; t_xsel = '0; t_ysel = '0;
        t_oen = '0; t_busy = '0; t_done = '0; t_err = '0;
        ext_x = x;
        ext_y = y;
        @(posedge clock); #1;
        bus.start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            t_xen[c]  = bus.x_en;
            t_yen[c]  = bus.y_en;
            t_xsel[c] = bus.x_sel;
            t_ysel[c] = bus.y_sel;
            t_oen[c]  = bus.output_en;
            t_busy[c] = bus.busy;
            t_done[c] = bus.done;
            t_err[c]  = bus.err;
            @(posedge clock); #1;
            if (!hold) bus.start = 1'b0;
        end
    endtask

    initial begin
        bus.start = 1'b0;

        // Reset state
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err",  32'(bus.err), 0);
        chk("rst_iter", 32'(bus.iter_count), 0);
        chk("rst_en",   32'({bus.x_en, bus.y_en, bus.output_en}), 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // 1: 12, 8 -> 4 after 2 subtractions
        run_op(32'd12, 32'd8, 1'b0, 10);
        chk("t1_load",    32'(t_xen[1] & t_yen[1]), 1);
        chk("t1_xen_c2",  32'({t_xen[2], t_xsel[2], t_yen[2]}), 32'b110);
        chk("t1_yen_c3",  32'({t_yen[3], t_ysel[3], t_xen[3]}), 32'b110);
        chk("t1_oen",     32'(first_hi(t_oen)), 4);
        chk("t1_done",    32'(first_hi(t_done)), 5);
        chk("t1_done_n",  32'($countones(t_done)), 1);
        chk("t1_out",     dp_out, 4);
        chk("t1_iter",    32'(bus.iter_count), 2);
        chk("t1_err",     32'(bus.err), 0);

        // 2: equal operands
        run_op(32'd7, 32'd7, 1'b0, 8);
        chk("t2_oen",  32'(first_hi(t_oen)), 2);
        chk("t2_done", 32'(first_hi(t_done)), 3);
        chk("t2_out",  dp_out, 7);
        chk("t2_iter", 32'(bus.iter_count), 0);

        // 3: 1071, 462 -> 21 after 11 subtractions
        run_op(32'd1071, 32'd462, 1'b0, 20);
        chk("t3_out",    dp_out, 21);
        chk("t3_iter",   32'(bus.iter_count), 11);
        chk("t3_done",   32'(first_hi(t_done)), 14);
        chk("t3_busy_n", 32'($countones(t_busy)), 13);
        chk("t3_busy_w", 32'({t_busy[14], t_busy[13], t_busy[1], t_busy[0]}), 32'b0110);

        // 4: one zero operand hits the limit
        run_op(32'd0, 32'd5, 1'b0, 24);
        chk("t4_yen_n",  32'($countones(t_yen[23:2])), 16);
        chk("t4_yen_17", 32'({t_yen[18], t_yen[17]}), 32'b01);
        chk("t4_err",    32'({t_err[19], t_err[18]}), 32'b10);
        chk("t4_busy19", 32'(t_busy[19]), 0);
        chk("t4_nodone", 32'(|t_done), 0);
        chk("t4_iter",   32'(bus.iter_count), 16);
        chk("t4_err_hd", 32'(bus.err), 1);

        // 4b: restart from ERR clears the error
        run_op(32'd9, 32'd6, 1'b0, 10);
        chk("t4b_err0", 32'(t_err[0]), 1);
        chk("t4b_err2", 32'(t_err[2]), 0);
        chk("t4b_out",  dp_out, 3);
        chk("t4b_iter", 32'(bus.iter_count), 2);
        chk("t4b_done", 32'(first_hi(t_done)), 5);

        // 5: start held high the whole time
        run_op(32'd12, 32'd8, 1'b1, 8);
        chk("t5_noreld", 32'($countones(t_xen[5:2] & t_yen[5:2])), 0);
        chk("t5_done",   32'(first_hi(t_done)), 5);
        chk("t5_reload", 32'({t_xen[6], t_yen[6], t_busy[6], t_xsel[6]}), 32'b1110);
        bus.start = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        chk("t5_out",  dp_out, 4);
        chk("t5_idle", 32'(bus.busy), 0);

        // 6: asynchronous reset in cycle 3
        ext_x = 32'd12;
        ext_y = 32'd8;
        @(posedge clock); #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        chk("t6_pre_yen", 32'(bus.y_en), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_en",   32'({bus.x_en, bus.y_en, bus.output_en, bus.done}), 0);
        chk("t6_iter", 32'(bus.iter_count), 0);
        chk("t6_err",  32'(bus.err), 0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        run_op(32'd9, 32'd6, 1'b0, 10);
        chk("t6_out",  dp_out, 3);
        chk("t6_iter2", 32'(bus.iter_count), 2);
        chk("t6_done", 32'(first_hi(t_done)), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gcd_control.md
Name: gcd_control

Overview:
Control FSM that drives the 32-bit GCD datapath using its select, enable and output-latch inputs. It reacts to the datapath's x_lt_y/x_ne_y flags.
- Adds a start/busy/done handshake toward the issuing logic.
- Counts subtraction iterations.
- Flags a timeout error, so zero operands cannot hang the system.

Parameters:
ITER_W, 16, width of the iteration counter.
MAX_ITER, 1000, subtraction limit before error; must be less than 2^ITER_W and at least 1.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request new GCD; sampled in IDLE, DONE or ERR only.
x_lt_y  input  1  datapath flag: X register < Y register.
x_ne_y  input  1  datapath flag: X register != Y register.
x_sel  output  1  datapath X mux: 0 = external X, 1 = X-Y difference.
y_sel  output  1  datapath Y mux: 0 = external Y, 1 = Y-X difference.
x_en  output  1  X register load enable.
y_en  output  1  Y register load enable.
output_en  output  1  latch X register into datapath output register.
busy  output  1  high in LOAD and RUN.
done  output  1  one-cycle pulse: result valid in datapath output register.
err  output  1  sticky timeout flag; held until next start or reset.
iter_count  output  ITER_W  subtractions performed in the current or last operation.

Behaviour:
- States: IDLE, LOAD, RUN, DONE, ERR. State, err and iter_count are registered.
- Datapath control outputs are combinational from state and flags. All are 0 unless listed below.
- Reset (reset=0), at any time including mid-operation:
  - state = IDLE; err = 0; iter_count = 0; all outputs 0.
  - The datapath is not touched; its own reset clears it.
- IDLE:
  - busy=0.
  - start=1: next state LOAD.
- LOAD (one cycle):
  - x_sel=0, y_sel=0, x_en=1, y_en=1, busy=1.
  - iter_count cleared to 0; err cleared to 0.
  - Next state RUN.
- RUN (busy=1); flags reflect the registers loaded on the previous edge:
  - x_ne_y=0: output_en=1; next state DONE.
  - Else if iter_count == MAX_ITER: no enables asserted; next state ERR; err set to 1.
  - Else if x_lt_y=1: y_sel=1, y_en=1 (Y <= Y-X); iter_count += 1; stay in RUN.
  - Else: x_sel=1, x_en=1 (X <= X-Y); iter_count += 1; stay in RUN.
- DONE (one cycle):
  - done=1, busy=0.
  - start=1: next state LOAD (back-to-back operation). Else: next state IDLE.
- ERR:
  - err=1, busy=0, iter_count holds MAX_ITER.
  - start=1: next state LOAD.
- start is ignored in LOAD and RUN; holding start high does not restart a running operation.
- Latency from the start edge (cycle 0 = start sampled in IDLE):
  - LOAD in cycle 1, RUN from cycle 2.
  - Result needing n subtractions: output_en in cycle 2+n, done in cycle 3+n.
  - Datapath output register holds the result from the edge ending cycle 2+n.
- iter_count never wraps: bounded by MAX_ITER. It holds its final value in IDLE/DONE/ERR until the next LOAD.
- X = Y = 0: equal on the first RUN cycle, so result 0, n=0, no error.
- Exactly one zero operand: never converges; ends in ERR after MAX_ITER subtractions.

Test Plan:
1. X=12, Y=8, start pulse in cycle 0:
   - x_en in cycle 2, y_en in cycle 3, output_en in cycle 4.
   - done in cycle 5; out=4; iter_count=2; err=0.
2. X=7, Y=7:
   - output_en in cycle 2, done in cycle 3; out=7; iter_count=0.
3. X=1071, Y=462:
   - out=21; iter_count=11; done in cycle 14; busy high in cycles 1-13 only.
4. MAX_ITER=16, X=0, Y=5:
   - 16 y_en cycles (cycles 2-17); ERR entered after cycle 18; err=1; iter_count=16; done never asserted.
   - Then start with X=9, Y=6: err clears in LOAD; out=3; iter_count=2.
5. start held high continuously with X=12, Y=8:
   - No re-LOAD during RUN; done in cycle 5.
   - LOAD again in cycle 6 (DONE->LOAD path), with no IDLE cycle.
6. reset driven low in cycle 3 of the X=12, Y=8 run:
   - Outputs go to 0 immediately (asynchronously); state IDLE; iter_count=0; err=0.
   - After reset deassertion, a new start completes normally.
